// File: rtl/gpio_display_pkg.sv
// Shared types and constants for the GPIO seven-segment display.
// No logic lives here; only the FSM state type, the segment table and the digit counts.
package gpio_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam int         BCD_DIGITS  = 10;
    localparam int         DISP_DIGITS = 8;

    // Active-low segments {g,f,e,d,c,b,a}; entry 0 sits in the least-significant slot.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/gpio_display_seg7_decode.sv
// Purpose: one hex digit to active-low seven-segment pattern, with a blank override.
// Latency: combinational. Backpressure: none.
module seg7_decode
    import gpio_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_LUT[digit];

endmodule

// File: rtl/gpio_display.sv
// Purpose: shows the CPU GPIO_out word on eight seven-segment digits, decimal or hex.
// Latency: 35 cycles decimal, 3 cycles hex. Backpressure: none; input changes mid-conversion are picked up afterwards.
module gpio_display
    import gpio_display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1,
    parameter int ITER     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_out,
    input  logic        hex_mode,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy,
    output logic        valid,
    output logic        overflow
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t                          state, state_nxt;
    logic                            pending;
    logic                            start;
    logic [31:0]                     last_val;
    logic                            last_mode;
    logic [31:0]                     bin;
    logic [4*BCD_DIGITS-1:0]         bcd, bcd_adj;
    logic [CNT_W-1:0]                cnt;
    logic [DISP_DIGITS-1:0][6:0]     hex_q, seg_nxt;
    logic [DISP_DIGITS-1:0][3:0]     src_dig;
    logic [DISP_DIGITS-1:0]          blank;
    logic                            ovf_nxt;
    logic                            seen_nz;

    assign start = pending || (gpio_out != last_val) || (hex_mode != last_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: state_nxt = hex_mode ? LOAD : SHIFT;
            SHIFT:   if (cnt == CNT_W'(ITER - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Digit source and leading-zero blanking, scanned from the most-significant digit down.
    always_comb begin
        ovf_nxt = last_mode ? 1'b0 : |bcd[4*BCD_DIGITS-1:4*DISP_DIGITS];
        seen_nz = 1'b0;
        blank   = '0;
        src_dig = '0;
        for (int i = DISP_DIGITS - 1; i >= 0; i--) begin
            src_dig[i] = last_mode ? last_val[4*i +: 4] : bcd[4*i +: 4];
            seen_nz    = seen_nz || (src_dig[i] != 4'd0);
            blank[i]   = BLANK_LZ && !ovf_nxt && !seen_nz && (i != 0);
        end
    end

    for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_seg
        seg7_decode u_dec (
            .digit (src_dig[g]),
            .blank (blank[g]),
            .seg   (seg_nxt[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q     <= {DISP_DIGITS{SEG_BLANK}};
            busy      <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            last_val  <= '0;
            last_mode <= 1'b0;
            pending   <= 1'b1;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    bin       <= gpio_out;
                    last_val  <= gpio_out;
                    last_mode <= hex_mode;
                    bcd       <= '0;
                    cnt       <= '0;
                    pending   <= 1'b0;
                    busy      <= 1'b1;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                end
                LOAD: begin
                    hex_q    <= seg_nxt;
                    overflow <= ovf_nxt;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule

// File: tb/tb_gpio_display.sv
// Directed bench for gpio_display: expected displays are queued when a value is driven
// and popped when the DUT finishes a conversion.
module tb_gpio_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_out;
    logic        hex_mode;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy, valid, overflow;
    logic [55:0] disp;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0][6:0] segs;
        logic            ovf;
    } exp_t;

    exp_t q[$];

    gpio_display dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_out (gpio_out),
        .hex_mode (hex_mode),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .hex6     (hex6),
        .hex7     (hex7),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    assign disp = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] v, input logic m);
        exp_t        e;
        logic [3:0]  d [8];
        logic [31:0] tmp;
        logic        nz;
        if (m) begin
            e.ovf = 1'b0;
            for (int i = 0; i < 8; i++) d[i] = v[4*i +: 4];
        end else begin
            e.ovf = (v > 32'd99999999);
            tmp   = v % 32'd100000000;
            for (int i = 0; i < 8; i++) begin
                d[i] = 4'(tmp % 32'd10);
                tmp  = tmp / 32'd10;
            end
        end
        nz = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (d[i] != 4'd0) nz = 1'b1;
            e.segs[i] = (!e.ovf && !nz && i != 0) ? 7'h7F : seg_of(d[i]);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [31:0] v, input logic m);
        @(negedge clk);
        gpio_out = v;
        hex_mode = m;
        q.push_back(model(v, m));
    endtask

    // Runs until busy has been seen and dropped; the display may only change on that last sample.
    task automatic wait_done(input string tag, input int budget, output int cycles, output int busy_cyc);
        bit          seen = 1'b0;
        bit          done = 1'b0;
        bit          torn = 1'b0;
        logic [55:0] prev;
        prev     = disp;
        cycles   = 0;
        busy_cyc = 0;
        if (busy) seen = 1'b1;
        while (cycles < budget && !done) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) begin
                seen = 1'b1;
                busy_cyc++;
            end else if (seen) begin
                done = 1'b1;
            end
            if (disp !== prev && !done) torn = 1'b1;
            prev = disp;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_no_tear"}, torn, 0);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_segs"}, disp, e.segs);
            check({tag, "_ovf"}, overflow, e.ovf);
            check({tag, "_valid"}, valid, 1);
            check({tag, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        int c, b;
        rst      = 1'b1;
        gpio_out = 32'd0;
        hex_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_segs", disp, {8{7'h7F}});
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);

        // First value after reset is shown even though it equals the reset last_val.
        q.push_back(model(32'd0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        wait_done("zero", 60, c, b);
        check("zero_lat", c, 35);
        pop_check("zero");

        drive(32'd12345678, 1'b0);
        wait_done("dec", 60, c, b);
        check("dec_lat", c, 35);
        check("dec_busy_cycles", b, 33);
        pop_check("dec");

        drive(32'h00BC614E, 1'b1);
        wait_done("hex", 60, c, b);
        check("hex_lat", c, 3);
        pop_check("hex");

        drive(32'd100000000, 1'b0);
        wait_done("ovf", 60, c, b);
        check("ovf_flag", overflow, 1);
        pop_check("ovf");

        // Mode change alone must retrigger.
        drive(32'd100000000, 1'b1);
        wait_done("mode", 60, c, b);
        check("mode_lat", c, 3);
        pop_check("mode");

        drive(32'hFFFFFFFF, 1'b0);
        wait_done("max", 60, c, b);
        pop_check("max");

        drive(32'd0, 1'b1);
        wait_done("hexzero", 60, c, b);
        pop_check("hexzero");

        // Change input during SHIFT iteration 10.
        drive(32'd5, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        gpio_out = 32'd9;
        q.push_back(model(32'd9, 1'b0));
        wait_done("mid5", 60, c, b);
        pop_check("mid5");
        wait_done("mid9", 60, c, b);
        check("mid9_lat_le35", (c <= 35), 1);
        pop_check("mid9");

        // Reset during SHIFT iteration 20.
        drive(32'd87654321, 1'b0);
        repeat (22) @(posedge clk);
        #1;
        check("prev_valid_held", valid, 1);
        check("mid_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_segs", disp, {8{7'h7F}});
        check("arst_busy", busy, 0);
        check("arst_valid", valid, 0);
        check("arst_ovf", overflow, 0);
        void'(q.pop_back());
        @(negedge clk);
        q.push_back(model(32'd87654321, 1'b0));
        rst = 1'b0;
        wait_done("reconv", 60, c, b);
        check("reconv_lat", c, 35);
        pop_check("reconv");

        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
